// File: rtl/mem_arbiter_if.sv
// Signal bundle between the IFU/LSU requesters, the arbiter and the memory port.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  ifu_req_valid;
    logic                  ifu_req_ready;
    logic [ADDR_W-1:0]     ifu_req_addr;
    logic                  ifu_resp_valid;
    logic                  ifu_resp_ready;
    logic [DATA_W-1:0]     ifu_resp_rdata;
    logic                  ifu_resp_err;

    logic                  lsu_req_valid;
    logic                  lsu_req_ready;
    logic [ADDR_W-1:0]     lsu_req_addr;
    logic                  lsu_req_wen;
    logic [DATA_W-1:0]     lsu_req_wdata;
    logic [DATA_W/8-1:0]   lsu_req_wmask;
    logic                  lsu_resp_valid;
    logic                  lsu_resp_ready;
    logic [DATA_W-1:0]     lsu_resp_rdata;
    logic                  lsu_resp_err;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_W-1:0]     mem_req_addr;
    logic                  mem_req_wen;
    logic [DATA_W-1:0]     mem_req_wdata;
    logic [DATA_W/8-1:0]   mem_req_wmask;
    logic                  mem_resp_valid;
    logic                  mem_resp_ready;
    logic [DATA_W-1:0]     mem_resp_rdata;
    logic                  mem_resp_err;

    modport master (
        input  ifu_req_valid, ifu_req_addr, ifu_resp_ready,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_rdata, ifu_resp_err,
        input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
        input  lsu_resp_ready,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        output mem_resp_ready,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
    );

    modport slave (
        output ifu_req_valid, ifu_req_addr, ifu_resp_ready,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_rdata, ifu_resp_err,
        output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
        output lsu_resp_ready,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        input  mem_resp_ready,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin, single-outstanding arbiter sharing one memory port between IFU and LSU.
// The granted requester owns the port from request forward until its response completes.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.master bus
);
    localparam int MASK_W = DATA_W / 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic IFU = 1'b0;
    localparam logic LSU = 1'b1;

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;

    logic              any_req;
    logic              sel;
    logic              fwd;
    logic              in_resp;
    logic              lsu_fwd;
    logic              resp_ready;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic [MASK_W-1:0] wmask_sel;

    always_comb begin
        any_req = bus.ifu_req_valid | bus.lsu_req_valid;
        // In IDLE the grant is decided live; afterwards the latched owner keeps the port.
        if (state_q == IDLE) begin
            if (bus.ifu_req_valid && bus.lsu_req_valid) begin
                sel = ~last_grant_q;
            end else begin
                sel = bus.lsu_req_valid;
            end
        end else begin
            sel = owner_q;
        end
        fwd        = ((state_q == IDLE) && any_req) || (state_q == REQ);
        in_resp    = (state_q == RESP);
        lsu_fwd    = fwd && (sel == LSU);
        addr_sel   = (sel == LSU) ? bus.lsu_req_addr : bus.ifu_req_addr;
        wdata_sel  = lsu_fwd ? bus.lsu_req_wdata : '0;
        wmask_sel  = lsu_fwd ? bus.lsu_req_wmask : '0;
        resp_ready = in_resp && ((owner_q == LSU) ? bus.lsu_resp_ready : bus.ifu_resp_ready);
    end

    assign bus.mem_req_valid  = fwd;
    assign bus.mem_req_addr   = addr_sel;
    assign bus.mem_req_wen    = lsu_fwd && bus.lsu_req_wen;
    assign bus.mem_req_wdata  = wdata_sel;
    assign bus.mem_req_wmask  = wmask_sel;
    assign bus.ifu_req_ready  = fwd && (sel == IFU) && bus.mem_req_ready;
    assign bus.lsu_req_ready  = lsu_fwd && bus.mem_req_ready;

    assign bus.mem_resp_ready = resp_ready;
    assign bus.ifu_resp_valid = in_resp && (owner_q == IFU) && bus.mem_resp_valid;
    assign bus.ifu_resp_rdata = (in_resp && (owner_q == IFU)) ? bus.mem_resp_rdata : '0;
    assign bus.ifu_resp_err   = in_resp && (owner_q == IFU) && bus.mem_resp_err;
    assign bus.lsu_resp_valid = in_resp && (owner_q == LSU) && bus.mem_resp_valid;
    assign bus.lsu_resp_rdata = (in_resp && (owner_q == LSU)) ? bus.mem_resp_rdata : '0;
    assign bus.lsu_resp_err   = in_resp && (owner_q == LSU) && bus.mem_resp_err;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = sel;
                    state_d = bus.mem_req_ready ? RESP : REQ;
                end
            end
            REQ: begin
                if (bus.mem_req_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.mem_resp_valid && resp_ready) begin
                    state_d      = IDLE;
                    last_grant_d = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= IFU;
            last_grant_q <= LSU;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: is the port busy, has the owner's request been accepted, who owns it,
    // and who was served last (for the round-robin tie-break).
    bit m_busy = 1'b0;
    bit m_acc  = 1'b0;
    bit m_who  = 1'b0;
    bit m_prev = 1'b1;

    bit rec = 1'b0;
    bit grants[$];

    always @(negedge clk) begin : cmp
        bit iv, lv, win, fwd, r, mrr;
        iv  = bus.ifu_req_valid;
        lv  = bus.lsu_req_valid;
        win = m_busy ? m_who : ((iv && lv) ? !m_prev : lv);
        fwd = m_busy ? !m_acc : (iv || lv);
        r   = m_busy && m_acc;
        mrr = r && (m_who ? bus.lsu_resp_ready : bus.ifu_resp_ready);

        chk("m_req_valid", bus.mem_req_valid, fwd);
        if (fwd) chk("m_req_addr", bus.mem_req_addr, win ? bus.lsu_req_addr : bus.ifu_req_addr);
        chk("m_req_wen", bus.mem_req_wen, fwd && win && bus.lsu_req_wen);
        chk("m_req_wdata", bus.mem_req_wdata, (fwd && win) ? bus.lsu_req_wdata : '0);
        chk("m_req_wmask", bus.mem_req_wmask, (fwd && win) ? bus.lsu_req_wmask : '0);
        chk("m_ifu_req_ready", bus.ifu_req_ready, fwd && !win && bus.mem_req_ready);
        chk("m_lsu_req_ready", bus.lsu_req_ready, fwd && win && bus.mem_req_ready);
        chk("m_ifu_resp_valid", bus.ifu_resp_valid, r && !m_who && bus.mem_resp_valid);
        chk("m_lsu_resp_valid", bus.lsu_resp_valid, r && m_who && bus.mem_resp_valid);
        chk("m_mem_resp_ready", bus.mem_resp_ready, mrr);
        if (r && !m_who) begin
            chk("m_ifu_rdata", bus.ifu_resp_rdata, bus.mem_resp_rdata);
            chk("m_ifu_err", bus.ifu_resp_err, bus.mem_resp_err);
        end else begin
            chk("m_ifu_err_idle", bus.ifu_resp_err, 1'b0);
        end
        if (r && m_who) begin
            chk("m_lsu_rdata", bus.lsu_resp_rdata, bus.mem_resp_rdata);
            chk("m_lsu_err", bus.lsu_resp_err, bus.mem_resp_err);
        end else begin
            chk("m_lsu_err_idle", bus.lsu_resp_err, 1'b0);
        end

        if (rec && bus.mem_req_valid && bus.mem_req_ready) grants.push_back(bus.lsu_req_ready);

        if (rst) begin
            m_busy = 1'b0; m_acc = 1'b0; m_who = 1'b0; m_prev = 1'b1;
        end else if (!m_busy) begin
            if (iv || lv) begin
                m_busy = 1'b1; m_who = win; m_acc = bus.mem_req_ready;
            end
        end else if (!m_acc) begin
            if (bus.mem_req_ready) m_acc = 1'b1;
        end else if (bus.mem_resp_valid && mrr) begin
            m_busy = 1'b0; m_prev = m_who;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.ifu_req_valid  = 1'b0; bus.ifu_req_addr  = '0; bus.ifu_resp_ready = 1'b0;
        bus.lsu_req_valid  = 1'b0; bus.lsu_req_addr  = '0; bus.lsu_req_wen    = 1'b0;
        bus.lsu_req_wdata  = '0;   bus.lsu_req_wmask = '0; bus.lsu_resp_ready = 1'b0;
        bus.mem_req_ready  = 1'b0; bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = '0;   bus.mem_resp_err  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clr();
        do_reset();
        #1;
        chk("rst_mem_req_valid", bus.mem_req_valid, 1'b0);
        chk("rst_ifu_req_ready", bus.ifu_req_ready, 1'b0);
        chk("rst_mem_resp_ready", bus.mem_resp_ready, 1'b0);

        // IFU-only read with zero-latency forward
        bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h8000_0000; bus.mem_req_ready = 1'b1;
        #1;
        chk("t1_req_valid", bus.mem_req_valid, 1'b1);
        chk("t1_req_addr", bus.mem_req_addr, 32'h8000_0000);
        chk("t1_req_wen", bus.mem_req_wen, 1'b0);
        chk("t1_ifu_ready", bus.ifu_req_ready, 1'b1);
        cyc();
        bus.ifu_req_valid = 1'b0; bus.mem_req_ready = 1'b0;
        bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = 32'h0000_0413; bus.ifu_resp_ready = 1'b1;
        #1;
        chk("t1_resp_valid", bus.ifu_resp_valid, 1'b1);
        chk("t1_resp_rdata", bus.ifu_resp_rdata, 32'h0000_0413);
        chk("t1_lsu_resp_valid", bus.lsu_resp_valid, 1'b0);
        cyc();

        // Simultaneous requests after reset: IFU first, then the LSU write
        do_reset();
        bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h0000_0100;
        bus.lsu_req_valid = 1'b1; bus.lsu_req_addr = 32'h8000_1000; bus.lsu_req_wen = 1'b1;
        bus.lsu_req_wdata = 32'hDEAD_BEEF; bus.lsu_req_wmask = 4'hF; bus.mem_req_ready = 1'b1;
        #1;
        chk("t2_ifu_ready", bus.ifu_req_ready, 1'b1);
        chk("t2_lsu_ready", bus.lsu_req_ready, 1'b0);
        chk("t2_addr_ifu", bus.mem_req_addr, 32'h0000_0100);
        chk("t2_wen_ifu", bus.mem_req_wen, 1'b0);
        cyc();
        bus.ifu_req_valid = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = 32'h1111_2222;
        bus.ifu_resp_ready = 1'b1; bus.lsu_resp_ready = 1'b1;
        #1;
        chk("t2_lsu_ready_resp", bus.lsu_req_ready, 1'b0);
        cyc();
        bus.mem_resp_valid = 1'b0;
        #1;
        chk("t2_lsu_wen", bus.mem_req_wen, 1'b1);
        chk("t2_lsu_addr", bus.mem_req_addr, 32'h8000_1000);
        chk("t2_lsu_wdata", bus.mem_req_wdata, 32'hDEAD_BEEF);
        chk("t2_lsu_wmask", bus.mem_req_wmask, 4'hF);
        chk("t2_lsu_ready", bus.lsu_req_ready, 1'b1);
        cyc();
        bus.lsu_req_valid = 1'b0; bus.mem_resp_valid = 1'b1;
        #1;
        chk("t2_lsu_resp", bus.lsu_resp_valid, 1'b1);
        chk("t2_ifu_resp", bus.ifu_resp_valid, 1'b0);
        cyc();
        clr();

        // Both continuously valid: grants alternate
        grants.delete();
        rec = 1'b1;
        bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h0000_0200;
        bus.lsu_req_valid = 1'b1; bus.lsu_req_addr = 32'h8000_1004;
        bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b1;
        bus.ifu_resp_ready = 1'b1; bus.lsu_resp_ready = 1'b1;
        for (int i = 0; i < 12; i++) cyc();
        rec = 1'b0;
        clr();
        chk("t3_grant_count", grants.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < grants.size()) chk("t3_grant_order", grants[i], i % 2);
        end
        cyc();

        // LSU stalled in REQ while the IFU waits
        bus.lsu_req_valid = 1'b1; bus.lsu_req_addr = 32'h8000_2000;
        #1;
        chk("t4_req_valid", bus.mem_req_valid, 1'b1);
        chk("t4_lsu_ready0", bus.lsu_req_ready, 1'b0);
        cyc();
        for (int i = 0; i < 2; i++) begin
            bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h0000_0300;
            #1;
            chk("t4_addr_held", bus.mem_req_addr, 32'h8000_2000);
            chk("t4_ifu_blocked", bus.ifu_req_ready, 1'b0);
            cyc();
        end
        bus.mem_req_ready = 1'b1;
        #1;
        chk("t4_lsu_accept", bus.lsu_req_ready, 1'b1);
        chk("t4_ifu_blocked_acc", bus.ifu_req_ready, 1'b0);
        cyc();

        // Owner stalls its response; error goes to the LSU only
        bus.lsu_req_valid = 1'b0;
        bus.mem_resp_valid = 1'b1; bus.mem_resp_err = 1'b1; bus.mem_resp_rdata = 32'h0000_0055;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("t5_mem_resp_ready0", bus.mem_resp_ready, 1'b0);
            chk("t5_resp_held", bus.lsu_resp_valid, 1'b1);
            chk("t5_ifu_req_blocked", bus.ifu_req_ready, 1'b0);
            cyc();
        end
        bus.lsu_resp_ready = 1'b1;
        #1;
        chk("t5_mem_resp_ready", bus.mem_resp_ready, 1'b1);
        chk("t5_lsu_err", bus.lsu_resp_err, 1'b1);
        chk("t5_ifu_err", bus.ifu_resp_err, 1'b0);
        cyc();

        // IFU completes, then reset lands during the LSU response
        bus.mem_resp_valid = 1'b0; bus.mem_resp_err = 1'b0; bus.lsu_resp_ready = 1'b0;
        #1;
        chk("t6_ifu_grant", bus.ifu_req_ready, 1'b1);
        cyc();
        bus.ifu_req_valid = 1'b0; bus.mem_resp_valid = 1'b1; bus.ifu_resp_ready = 1'b1;
        cyc();
        bus.mem_resp_valid = 1'b0; bus.ifu_resp_ready = 1'b0;
        bus.lsu_req_valid = 1'b1; bus.lsu_req_addr = 32'h8000_3000;
        cyc();
        bus.lsu_req_valid = 1'b0; bus.mem_resp_valid = 1'b1; rst = 1'b1;
        cyc();
        rst = 1'b0;
        clr();
        #1;
        chk("t6_post_rst_req_valid", bus.mem_req_valid, 1'b0);
        chk("t6_post_rst_ifu_resp", bus.ifu_resp_valid, 1'b0);
        chk("t6_post_rst_lsu_resp", bus.lsu_resp_valid, 1'b0);
        chk("t6_post_rst_resp_ready", bus.mem_resp_ready, 1'b0);
        bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h0000_0400;
        bus.lsu_req_valid = 1'b1; bus.lsu_req_addr = 32'h8000_4000; bus.mem_req_ready = 1'b1;
        #1;
        chk("t6_tie_ifu", bus.ifu_req_ready, 1'b1);
        chk("t6_tie_lsu", bus.lsu_req_ready, 1'b0);
        chk("t6_tie_addr", bus.mem_req_addr, 32'h0000_0400);
        cyc();
        bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
        bus.mem_resp_valid = 1'b1; bus.ifu_resp_ready = 1'b1;
        cyc();
        clr();
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester, single-outstanding arbiter that shares one memory port between the instruction fetch path (IFU, read-only) and the load/store path (LSU, read/write).
- Sits between fetch/LSU and the memory/bus bridge.
- Request and response channels use valid/ready handshakes.
- One transaction is in flight at a time; the granted requester owns the port until its response completes.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; write mask is DATA_W/8 bits

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ifu_req_valid  in  1  IFU read request valid
ifu_req_ready  out  1  IFU request accepted
ifu_req_addr  in  ADDR_W  IFU fetch address
ifu_resp_valid  out  1  IFU read data valid
ifu_resp_ready  in  1  IFU can take response
ifu_resp_rdata  out  DATA_W  IFU read data
ifu_resp_err  out  1  IFU access error
lsu_req_valid  in  1  LSU request valid
lsu_req_ready  out  1  LSU request accepted
lsu_req_addr  in  ADDR_W  LSU address
lsu_req_wen  in  1  1 = write, 0 = read
lsu_req_wdata  in  DATA_W  write data
lsu_req_wmask  in  DATA_W/8  byte write enables
lsu_resp_valid  out  1  LSU response valid
lsu_resp_ready  in  1  LSU can take response
lsu_resp_rdata  out  DATA_W  LSU read data (don't-care for writes)
lsu_resp_err  out  1  LSU access error
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  address
mem_req_wen  out  1  write enable
mem_req_wdata  out  DATA_W  write data
mem_req_wmask  out  DATA_W/8  byte mask
mem_resp_valid  in  1  memory response valid
mem_resp_ready  out  1  arbiter takes response
mem_resp_rdata  in  DATA_W  read data
mem_resp_err  in  1  error

Behaviour:
- Registers: state {IDLE, REQ, RESP}, owner (0 = IFU, 1 = LSU), last_grant.
- Reset: state = IDLE, last_grant = LSU so IFU wins the first tie. All *_valid and *_ready outputs are 0 while in IDLE with no requests. mem_req_wen/wdata/wmask drive 0 when the LSU is not selected.
- IDLE:
  - Grant: the sole valid requester wins. If both are valid, the requester that is not last_grant wins (round-robin).
  - The granted request is forwarded combinationally: mem_req_valid is asserted in the same cycle as the requester's valid (0-cycle latency).
  - IFU path forces mem_req_wen = 0 and wmask = 0.
  - The granted requester's req_ready = mem_req_ready; the other requester's req_ready = 0.
  - Handshake this cycle -> RESP with owner latched. Else, if any request is valid -> REQ with owner latched. Otherwise stay in IDLE.
- REQ:
  - Owner's request is forwarded and mem_req_valid is held. The grant does not change even if the other requester asserts valid.
  - On mem_req_ready -> RESP.
- RESP:
  - mem_req_valid = 0 and both req_ready = 0.
  - Owner's resp_valid/rdata/err = mem_resp_*; the other requester's resp_valid = 0.
  - mem_resp_ready = owner's resp_ready.
  - On mem_resp_valid & mem_resp_ready: state -> IDLE, last_grant <= owner.
- mem_resp_valid in IDLE/REQ is ignored: mem_resp_ready = 0 and nothing is routed.
- Requesters must hold valid and payload stable until ready. The arbiter never drops a granted request.
- Throughput: at most one transaction per 2 cycles. There is one IDLE cycle after each response before the next grant.
- Response stall: if the owner holds resp_ready = 0, the arbiter stays in RESP indefinitely and the other requester is blocked.
- Reset mid-transaction: unconditionally returns to IDLE with last_grant = LSU. The memory side is reset by the same rst; no response is delivered.

Test Plan:
- IFU-only read, addr 0x8000_0000, mem_req_ready = 1 same cycle, response rdata 0x0000_0413 one cycle later -> mem_req_valid asserted in cycle 0, ifu_resp_valid in cycle 1 with 0x0000_0413, lsu_resp_valid stays 0.
- Both valid in the same cycle after reset -> IFU granted first. LSU write (0x8000_1000, 0xDEAD_BEEF, wmask 0xF) is granted on the next IDLE, with mem_req_wen = 1 and matching payload.
- Both continuously valid for 6 transactions -> grants alternate IFU, LSU, IFU, LSU, IFU, LSU.
- LSU granted with mem_req_ready = 0 for 3 cycles while the IFU raises valid -> stays in REQ, LSU address held stable, ifu_req_ready = 0 throughout, LSU accepted on cycle 4.
- Owner resp_ready = 0 for 2 cycles while mem_resp_valid = 1 -> mem_resp_ready = 0, response held, delivered on the third cycle. mem_resp_err = 1 is propagated to the owner only.
- rst asserted during RESP -> next cycle IDLE, all valid outputs 0. Simultaneous requests afterwards grant IFU first.
